// File: rtl/led_strip_frame_driver.sv
// WS2812-style serial LED driver: double-buffered pixel store, GRB serialiser
// with cycle-exact bit timing, latch period and a completion pulse.
module led_strip_frame_driver #(
  parameter int NUM_LEDS = 16,
  parameter int CW       = 4,
  parameter int T0H      = 20,
  parameter int T1H      = 40,
  parameter int TBIT     = 63,
  parameter int TRST     = 2500,
  localparam int AW      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [3*CW-1:0] wr_rgb,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            data
);

  localparam int CMAX = (TBIT > TRST) ? TBIT : TRST;
  localparam int CNTW = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int PW   = 3 * CW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_LATCH,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] cyc_q, cyc_d;
  logic [4:0]      bit_q, bit_d;
  logic [AW-1:0]   pix_q, pix_d;
  logic [23:0]     word_q, word_d;
  logic            front_sel_q, front_sel_d;
  logic            data_q, data_d;

  logic [PW-1:0]   bank0 [NUM_LEDS];
  logic [PW-1:0]   bank1 [NUM_LEDS];
  logic [AW-1:0]   rd_addr;
  logic [PW-1:0]   rd_pix;
  logic            wr_ok;
  logic            last_pix;

  // Replicating the channel and keeping the top byte gives out[7-i] = c[CW-1 - (i mod CW)].
  function automatic logic [7:0] expand(input logic [CW-1:0] c);
    logic [8*CW-1:0] rep;
    rep = {8{c}};
    return rep[8*CW-1 -: 8];
  endfunction

  function automatic logic [23:0] to_wire(input logic [PW-1:0] p);
    return {expand(p[2*CW-1 -: CW]), expand(p[3*CW-1 -: CW]), expand(p[CW-1:0])};
  endfunction

  assign wr_ok    = wr_en && (int'(wr_addr) < NUM_LEDS);
  assign last_pix = (pix_q == AW'(NUM_LEDS - 1));
  assign rd_pix   = front_sel_q ? bank1[rd_addr] : bank0[rd_addr];

  // Writes always target the bank not selected by front_sel.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (front_sel_q) begin
        bank0[wr_addr] <= wr_rgb;
      end else begin
        bank1[wr_addr] <= wr_rgb;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    bit_d       = bit_q;
    pix_d       = pix_q;
    word_d      = word_q;
    front_sel_d = front_sel_q;
    rd_addr     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_LOAD;
          front_sel_d = ~front_sel_q;
        end
      end
      S_LOAD: begin
        state_d = S_SEND;
        cyc_d   = '0;
        bit_d   = '0;
        pix_d   = '0;
        word_d  = to_wire(rd_pix);
      end
      S_SEND: begin
        if (!last_pix) begin
          rd_addr = pix_q + 1'b1;
        end
        if (cyc_q == CNTW'(TBIT - 1)) begin
          cyc_d = '0;
          if (bit_q == 5'd23) begin
            bit_d = '0;
            if (last_pix) begin
              state_d = S_LATCH;
            end else begin
              pix_d  = pix_q + 1'b1;
              word_d = to_wire(rd_pix);
            end
          end else begin
            bit_d  = bit_q + 1'b1;
            word_d = {word_q[22:0], 1'b0};
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_LATCH: begin
        pix_d = '0;
        if (cyc_q == CNTW'(TRST - 1)) begin
          state_d = S_DONE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Output level is derived from the next-cycle position so data can be registered.
    data_d = (state_d == S_SEND) &&
             (cyc_d < (word_d[23] ? CNTW'(T1H) : CNTW'(T0H)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      pix_q   <= '0;
      word_q  <= '0;
      data_q  <= 1'b0;
      // An aborted frame leaves the bank selection untouched.
      if (state_q == S_IDLE) begin
        front_sel_q <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      bit_q       <= bit_d;
      pix_q       <= pix_d;
      word_q      <= word_d;
      front_sel_q <= front_sel_d;
      data_q      <= data_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign data = data_q;

endmodule
